// File: rtl/layer_sequencer_pkg.sv
// Shared state codes and stage-bit helpers for the inference layer sequencer.
package layer_sequencer_pkg;
  localparam int STATE_LEN = 3;

  typedef enum logic [STATE_LEN-1:0] {
    IDLE  = 3'd0,
    EMB   = 3'd1,
    MIX   = 3'd2,
    DENSE = 3'd3,
    COMP  = 3'd4
  } state_e;

  localparam int STG_EMB   = 0;
  localparam int STG_MIX   = 1;
  localparam int STG_DENSE = 2;
  localparam int STG_COMP  = 3;

  // Codes 5-7 are not real stages; they collapse to IDLE.
  function automatic state_e decode_state(input logic [STATE_LEN-1:0] code);
    case (code)
      3'd1:    return EMB;
      3'd2:    return MIX;
      3'd3:    return DENSE;
      3'd4:    return COMP;
      default: return IDLE;
    endcase
  endfunction

  function automatic logic [3:0] stage_mask(input state_e s);
    logic [3:0] m;
    m = '0;
    case (s)
      EMB:     m[STG_EMB]   = 1'b1;
      MIX:     m[STG_MIX]   = 1'b1;
      DENSE:   m[STG_DENSE] = 1'b1;
      COMP:    m[STG_COMP]  = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction
endpackage

// File: rtl/layer_sequencer_watchdog.sv
// Stage watchdog: counts launched-but-unfinished run cycles and flags expiry.
module seq_watchdog #(
  parameter int TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  // Expiry is seen on the edge that would bring the count to TIMEOUT.
  assign expire = inc && !clr && (cnt == W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (inc)      cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/layer_sequencer.sv
// Inference stage scheduler: IDLE -> EMB -> MIX x MIX_NUM -> DENSE -> COMP.
// Optional stage watchdog enabled by defining SEQ_TIMEOUT_EN.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int MIX_NUM = 4,
  parameter int CNT_W   = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 run,
  input  logic                 start,
  input  logic                 set,
  input  logic [STATE_LEN-1:0] d,
  input  logic [3:0]           done,
  output logic [STATE_LEN-1:0] q,
  output logic [3:0]           go,
  output logic [CNT_W-1:0]     layer_cnt,
  output logic                 busy,
  output logic                 finish,
  output logic                 err
);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MIX_NUM - 1);

  state_e           st, st_nxt;
  logic             pend, pend_nxt;
  logic             hold, hold_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [3:0]       go_nxt;
  logic             fin_nxt;
  logic             expire;
  logic [3:0]       cur_mask;
  logic             done_cur;

  assign cur_mask = stage_mask(st);
  assign done_cur = |(done & cur_mask);
  assign q        = st;

`ifdef SEQ_TIMEOUT_EN
  logic err_q;

  seq_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (set || pend || (st == IDLE)),
    .inc    (run && (st != IDLE) && !pend),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_q | expire;
  end
  assign err = err_q;
`else
  assign expire = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    st_nxt   = st;
    pend_nxt = pend;
    hold_nxt = hold;
    cnt_nxt  = layer_cnt;
    go_nxt   = '0;
    fin_nxt  = 1'b0;
    if (set) begin
      st_nxt   = decode_state(d);
      pend_nxt = (st_nxt != IDLE);
      hold_nxt = 1'b0;
      cnt_nxt  = '0;
    end else if (run) begin
      if (expire) begin
        st_nxt   = IDLE;
        pend_nxt = 1'b0;
        hold_nxt = 1'b0;
        cnt_nxt  = '0;
      end else if (st == IDLE) begin
        if (start) begin
          st_nxt   = EMB;
          pend_nxt = 1'b1;
        end
      end else if (pend) begin
        go_nxt   = cur_mask;
        pend_nxt = 1'b0;
      end else if (done_cur || hold) begin
        hold_nxt = 1'b0;
        pend_nxt = 1'b1;
        case (st)
          EMB: begin
            st_nxt  = MIX;
            cnt_nxt = '0;
          end
          MIX: begin
            if (layer_cnt < LAST_ITER) cnt_nxt = layer_cnt + CNT_W'(1);
            else begin
              st_nxt  = DENSE;
              cnt_nxt = '0;
            end
          end
          DENSE: st_nxt = COMP;
          COMP: begin
            st_nxt   = IDLE;
            pend_nxt = 1'b0;
            fin_nxt  = 1'b1;
          end
          default: st_nxt = IDLE;
        endcase
      end
    end else if ((st != IDLE) && !pend && done_cur) begin
      // Paused: remember the completion so it is applied when run returns.
      hold_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      pend      <= 1'b0;
      hold      <= 1'b0;
      layer_cnt <= '0;
      go        <= '0;
      finish    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      st        <= st_nxt;
      pend      <= pend_nxt;
      hold      <= hold_nxt;
      layer_cnt <= cnt_nxt;
      go        <= go_nxt;
      finish    <= fin_nxt;
      busy      <= (st_nxt != IDLE);
    end
  end
endmodule
